// File: rtl/btn_pkg.sv
// Shared definitions for the push-button decoder.
// Holds the decoder state encoding, the default 100 MHz timing constants and
// the counter-width helper used to size the debounce and hold counters.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms debounce and 1 s long-press at 100 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_LONG_CYCLES     = 100000000;

    // Counter width for a count of n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, clearable by a
// synchronous active-high reset. Reusable for any button or switch input.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - synchronised output (2 edges of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_press_decoder.sv
// Push-button decoder: synchronises and debounces a raw button and produces
// a clean level plus one-cycle press, release and long-press pulses.
// Ports:
//   Clk          - system clock (posedge)
//   Reset        - synchronous active-high reset
//   BTN          - raw button, asynchronous, active-high
//   Pressed      - debounced button level
//   PressPulse   - one cycle on an accepted press
//   ReleasePulse - one cycle on an accepted release
//   LongPulse    - one cycle when a press has been held LONG_CYCLES edges
module button_press_decoder
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BTN,
    output logic Pressed,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic LongPulse
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(LONG_CYCLES);

    // Counters stop one short of the parameter: the edge that sees the last
    // value is itself the Nth qualifying edge, so N never has to be stored.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          btn_s;
    btn_state_e    state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic          long_done_q;
    logic          pressed_q;
    logic          press_pulse_q;
    logic          release_pulse_q;
    logic          long_pulse_q;

    sync_2ff u_sync (
        .clk_i (Clk),
        .rst_i (Reset),
        .d_i   (BTN),
        .q_o   (btn_s)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            deb_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q   <= PRESS_WAIT;
                        deb_cnt_q <= DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q       <= HELD;
                        pressed_q     <= 1'b1;
                        press_pulse_q <= 1'b1;
                        hold_cnt_q    <= '0;
                        deb_cnt_q     <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_q   <= RELEASE_WAIT;
                        deb_cnt_q <= DW'(1);
                    end else if (!long_done_q) begin
                        // Hold counter freezes at its last value once fired.
                        if (hold_cnt_q == HOLD_LAST) begin
                            long_pulse_q <= 1'b1;
                            long_done_q  <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // Hold counter is left untouched so a rejected release
                    // resumes the long-press timing where it paused.
                    if (btn_s) begin
                        state_q   <= HELD;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q         <= IDLE;
                        pressed_q       <= 1'b0;
                        release_pulse_q <= 1'b1;
                        hold_cnt_q      <= '0;
                        long_done_q     <= 1'b0;
                        deb_cnt_q       <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Pressed      = pressed_q;
    assign PressPulse   = press_pulse_q;
    assign ReleasePulse = release_pulse_q;
    assign LongPulse    = long_pulse_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
// A run-length reference model predicts every output on every edge; directed
// scenarios additionally check pulse counts and edge distances.
module tb_button_press_decoder;

    localparam int D = 4;
    localparam int L = 16;

    logic Clk = 1'b0;
    logic Reset;
    logic BTN;
    logic Pressed, PressPulse, ReleasePulse, LongPulse;

    button_press_decoder #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .BTN          (BTN),
        .Pressed      (Pressed),
        .PressPulse   (PressPulse),
        .ReleasePulse (ReleasePulse),
        .LongPulse    (LongPulse)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    int pp_cnt, rp_cnt, lp_cnt, pp_edge, rp_edge, lp_edge;

    // Reference model: synchroniser pipe, accepted level, length of the
    // current run of samples disagreeing with it, held-edge count.
    logic m_s1 = 0, m_s2 = 0, m_pressed = 0, m_longdone = 0;
    logic m_pp = 0, m_rp = 0, m_lp = 0;
    int   m_run = 0, m_hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_edge(input logic btn, input logic rst);
        m_pp = 0; m_rp = 0; m_lp = 0;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_pressed = 0; m_longdone = 0;
            m_run = 0; m_hold = 0;
        end else begin
            if (m_s2 != m_pressed) begin
                m_run++;
                if (m_run == D) begin
                    m_pressed = m_s2;
                    m_run = 0;
                    m_hold = 0;
                    if (m_s2) m_pp = 1;
                    else begin m_rp = 1; m_longdone = 0; end
                end
            end else begin
                // Only an undisturbed held edge counts towards long press.
                if (m_pressed && m_run == 0 && !m_longdone) begin
                    m_hold++;
                    if (m_hold == L) begin m_lp = 1; m_longdone = 1; end
                end
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    task automatic clear_ev();
        pp_cnt = 0; rp_cnt = 0; lp_cnt = 0;
        pp_edge = -1; rp_edge = -1; lp_edge = -1;
    endtask

    task automatic tick(input logic btn, input logic rst);
        BTN = btn;
        Reset = rst;
        @(posedge Clk);
        model_edge(btn, rst);
        edge_no++;
        #1;
        chk("Pressed",      {31'd0, Pressed},      {31'd0, m_pressed});
        chk("PressPulse",   {31'd0, PressPulse},   {31'd0, m_pp});
        chk("ReleasePulse", {31'd0, ReleasePulse}, {31'd0, m_rp});
        chk("LongPulse",    {31'd0, LongPulse},    {31'd0, m_lp});
        if (PressPulse === 1'b1)   begin pp_cnt++; pp_edge = edge_no; end
        if (ReleasePulse === 1'b1) begin rp_cnt++; rp_edge = edge_no; end
        if (LongPulse === 1'b1)    begin lp_cnt++; lp_edge = edge_no; end
    endtask

    task automatic run(input logic btn, input int n);
        repeat (n) tick(btn, 1'b0);
    endtask

    initial begin
        int mark, fall;
        logic lvl;
        int len;

        // 1: reset with button held, then fresh debounce
        clear_ev();
        repeat (3) tick(1'b1, 1'b1);
        chk("rst_pp_cnt", pp_cnt, 0);
        mark = edge_no;
        run(1'b1, 8);
        chk("s1_pp_cnt", pp_cnt, 1);
        chk("s1_pp_edge", pp_edge - mark, 6);
        run(1'b0, 10);

        // 2: clean short press
        clear_ev();
        mark = edge_no;
        run(1'b1, 10);
        fall = edge_no;
        run(1'b0, 10);
        chk("s2_pp_cnt", pp_cnt, 1);
        chk("s2_pp_edge", pp_edge - mark, 6);
        chk("s2_rp_cnt", rp_cnt, 1);
        chk("s2_rp_edge", rp_edge - fall, 6);
        chk("s2_lp_cnt", lp_cnt, 0);

        // 3: bounces shorter than the debounce time
        clear_ev();
        run(1'b1, 3); run(1'b0, 1); run(1'b1, 3); run(1'b0, 10);
        chk("s3_pp_cnt", pp_cnt, 0);
        chk("s3_rp_cnt", rp_cnt, 0);

        // 4: long press
        clear_ev();
        mark = edge_no;
        run(1'b1, 40);
        fall = edge_no;
        run(1'b0, 10);
        chk("s4_pp_cnt", pp_cnt, 1);
        chk("s4_pp_edge", pp_edge - mark, 6);
        chk("s4_lp_cnt", lp_cnt, 1);
        chk("s4_lp_dist", lp_edge - pp_edge, L);
        chk("s4_rp_edge", rp_edge - fall, 6);

        // 5: release glitch while held pauses the long-press timer
        // (2 low samples plus the edge returning to held = 3 uncounted)
        clear_ev();
        run(1'b1, 8); run(1'b0, 2); run(1'b1, 30);
        fall = edge_no;
        run(1'b0, 10);
        chk("s5_pp_cnt", pp_cnt, 1);
        chk("s5_rp_cnt", rp_cnt, 1);
        chk("s5_rp_edge", rp_edge - fall, 6);
        chk("s5_lp_cnt", lp_cnt, 1);
        chk("s5_lp_dist", lp_edge - pp_edge, L + 3);

        // 6: reset while held after long press, button stays down
        clear_ev();
        run(1'b1, 30);
        chk("s6_lp_first", lp_cnt, 1);
        clear_ev();
        tick(1'b1, 1'b1);
        chk("s6_rst_pressed", {31'd0, Pressed}, 0);
        mark = edge_no;
        run(1'b1, 30);
        fall = edge_no;
        run(1'b0, 10);
        chk("s6_pp_cnt", pp_cnt, 1);
        chk("s6_pp_edge", pp_edge - mark, 6);
        chk("s6_lp_cnt", lp_cnt, 1);
        chk("s6_lp_dist", lp_edge - pp_edge, L);
        chk("s6_rp_cnt", rp_cnt, 1);
        chk("s6_rp_edge", rp_edge - fall, 6);

        // 7: random segments with occasional resets, model-checked
        for (int i = 0; i < 80; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 9) == 0) tick(lvl, 1'b1);
            run(lvl, len);
        end
        run(1'b0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
